pipe_ctrl: RTL

- Central pipeline controller for the 5-stage MIPS core.
- Turns stall requests from ID, EX and MEM into the 6-bit stall vector consumed by the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers.
- Sequences exception/ERET flushes: one freeze cycle, then a registered flush pulse with the redirect PC.
- Keeps a saturating stall-cycle counter and a sticky stall watchdog for debug.

---
 rtl/pipe_ctrl_if.sv | 24 ++
 rtl/pipe_ctrl.sv | 115 +++++++++++
 2 files changed

// File: rtl/pipe_ctrl_if.sv
// rtl/pipe_ctrl_if.sv - stall/flush bundle between the pipeline stages and pipe_ctrl
interface pipe_ctrl_if;
   logic        stallreq_id;
   logic        stallreq_ex;
   logic        stallreq_mem;
   logic [31:0] excepttype_i;
   logic [31:0] cp0_epc_i;
   logic [5:0]  stall_o;
   logic        flush_o;
   logic [31:0] new_pc_o;
   logic [31:0] stall_cycles_o;
   logic        stall_timeout_o;
   logic [1:0]  state_o;

   modport master (
      output stallreq_id, stallreq_ex, stallreq_mem, excepttype_i, cp0_epc_i,
      input  stall_o, flush_o, new_pc_o, stall_cycles_o, stall_timeout_o, state_o
   );

   modport slave (
      input  stallreq_id, stallreq_ex, stallreq_mem, excepttype_i, cp0_epc_i,
      output stall_o, flush_o, new_pc_o, stall_cycles_o, stall_timeout_o, state_o
   );
endinterface

// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - pipeline stall vector, exception freeze/flush sequencing, stall debug counters
module pipe_ctrl #(
   parameter logic [31:0] EXC_VECTOR    = 32'h0000_0020,
   parameter logic [31:0] ERET_CODE     = 32'h0000_000e,
   parameter int unsigned STALL_TIMEOUT = 1024
) (
   input  logic        clk,
   input  logic        rst,
   pipe_ctrl_if.slave  bus
);

   typedef enum logic [1:0] {
      ST_RUN    = 2'd0,
      ST_FREEZE = 2'd1,
      ST_FLUSH  = 2'd2
   } state_t;

   localparam logic [15:0] TIMEOUT = 16'(STALL_TIMEOUT);
   localparam logic [31:0] CNT_MAX = 32'hFFFF_FFFF;

   state_t      state_q;
   state_t      state_d;
   state_t      state_view;
   logic        take_exc;
   logic [5:0]  stall;
   logic        stall_run;
   logic        flush_q;
   logic [31:0] new_pc_q;
   logic [31:0] stall_cycles_q;
   logic [15:0] consec_q;
   logic        timeout_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_RUN;
      end else begin
         state_q <= state_d;
      end
   end

   // FREEZE is never registered: it is the RUN cycle in which an exception is visible.
   always_comb begin
      state_d    = state_q;
      state_view = state_q;
      stall      = 6'b000000;
      take_exc   = 1'b0;
      if (!rst) begin
         case (state_q)
            ST_RUN: begin
               if (bus.excepttype_i != 32'd0) begin
                  take_exc   = 1'b1;
                  stall      = 6'b111111;
                  state_d    = ST_FLUSH;
                  state_view = ST_FREEZE;
               end else if (bus.stallreq_mem) begin
                  stall = 6'b011111;
               end else if (bus.stallreq_ex) begin
                  stall = 6'b001111;
               end else if (bus.stallreq_id) begin
                  stall = 6'b000111;
               end
            end
            ST_FLUSH: begin
               state_d = ST_RUN;
            end
            default: begin
               state_d = ST_RUN;
            end
         endcase
      end
   end

   assign stall_run = (state_q == ST_RUN) && !take_exc && (stall != 6'b000000);

   always_ff @(posedge clk) begin
      if (rst) begin
         flush_q  <= 1'b0;
         new_pc_q <= 32'd0;
      end else begin
         flush_q <= take_exc;
         if (take_exc) begin
            new_pc_q <= (bus.excepttype_i == ERET_CODE) ? bus.cp0_epc_i : EXC_VECTOR;
         end
      end
   end

   // The freeze cycle neither counts nor breaks a run of consecutive stalls.
   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cycles_q <= 32'd0;
         consec_q       <= 16'd0;
         timeout_q      <= 1'b0;
      end else if (stall_run) begin
         if (stall_cycles_q != CNT_MAX) begin
            stall_cycles_q <= stall_cycles_q + 32'd1;
         end
         if (consec_q != TIMEOUT) begin
            consec_q <= consec_q + 16'd1;
         end
         if (consec_q >= TIMEOUT - 16'd1) begin
            timeout_q <= 1'b1;
         end
      end else if (stall == 6'b000000) begin
         consec_q <= 16'd0;
      end
   end

   assign bus.stall_o         = stall;
   assign bus.flush_o         = flush_q;
   assign bus.new_pc_o        = new_pc_q;
   assign bus.stall_cycles_o  = stall_cycles_q;
   assign bus.stall_timeout_o = timeout_q;
   assign bus.state_o         = state_view;

endmodule
